ghost_mode_scheduler: RTL and testbench
=======================================

Name: ghost_mode_scheduler

Overview:
Global behaviour sequencer for the enemy movement blocks. It steps the ghosts through timed SCATTER/CHASE phases, preempts them with FRIGHTENED mode on a power pellet, and issues one-cycle direction-reversal requests. It also produces the per-frame movement enable that the ghost datapaths use in place of the raw frame strobe. All timing counts frame_stb pulses (60 Hz).

Parameters:
SCATTER_FRAMES, 420, frame_stb pulses per scatter phase (>=1)
CHASE_FRAMES, 1200, frame_stb pulses per timed chase phase (>=1)
FRIGHT_FRAMES, 360, frame_stb pulses of frightened mode (>=1)
FLASH_FRAMES, 120, fright_flash asserted while fright remaining <= this value
NUM_PHASES, 4, scatter/chase pairs; the last chase is unbounded (1..4)
CNT_W, 11, timer width; must hold max(SCATTER_FRAMES, CHASE_FRAMES, FRIGHT_FRAMES)

Ports:
vga_pix_clk  in  1  pixel clock, single clock domain
rst  in  1  synchronous reset, active-high
frame_stb  in  1  one-cycle pulse per frame
game_start  in  1  pulse; starts sequencing from IDLE
pellet_eaten  in  1  pulse; power pellet consumed
ghost_eaten  in  1  pulse; Pac-Man ate a frightened ghost
pac_dead  in  1  pulse; Pac-Man died, abort to IDLE
mode  out  2  00 IDLE, 01 SCATTER, 10 CHASE, 11 FRIGHT
phase_idx  out  3  current scatter/chase phase, 0..2*NUM_PHASES-1
reverse_req  out  1  one-cycle pulse; ghosts reverse direction
move_en  out  1  gated frame_stb for ghost position update
fright_flash  out  1  frightened mode ending soon
eat_count  out  2  ghosts eaten in current fright (saturates at 3)

Behaviour:
- Reset: mode=IDLE, phase_idx=0, timer=0, saved state cleared, reverse_req=0, move_en=0, fright_flash=0, eat_count=0, fright toggle=0.
- Event priority per cycle: rst > pac_dead > game_start > pellet_eaten > timer expiry > frame_stb decrement.
- IDLE: move_en=0. game_start -> SCATTER, phase_idx=0, timer=SCATTER_FRAMES. pellet_eaten and ghost_eaten are ignored.
- SCATTER/CHASE: move_en = frame_stb combinationally.
  - On frame_stb with timer>1: timer decrements.
  - On frame_stb with timer==1: phase expires, so each phase lasts exactly N strobes. phase_idx increments, mode toggles, timer loads the new phase length, and reverse_req pulses in the following cycle.
  - Even phase_idx = SCATTER, odd = CHASE.
  - At phase_idx == 2*NUM_PHASES-1 (final CHASE): timer is frozen and no further expiry occurs.
- Entering FRIGHT from SCATTER/CHASE on pellet_eaten:
  - Save mode, phase_idx and timer. The timer is not decremented that cycle, even if frame_stb or expiry coincides.
  - Load timer=FRIGHT_FRAMES, eat_count=0, toggle=0, and pulse reverse_req.
- FRIGHT:
  - Each frame_stb flips toggle. move_en = frame_stb & toggle, so ghosts move on the 2nd, 4th, ... strobe after entry (half speed).
  - Timer decrements on frame_stb.
  - fright_flash = (timer <= FLASH_FRAMES).
  - ghost_eaten increments eat_count, saturating at 3.
  - pellet_eaten reloads timer=FRIGHT_FRAMES and clears eat_count. No reverse_req is issued and toggle is kept.
  - On frame_stb with timer==1: restore the saved mode, phase_idx and timer. The paused phase resumes with the same remaining count. No reverse_req. fright_flash=0. eat_count holds its value until the next fright entry.
- pac_dead in any state: same effect as reset except rst itself, i.e. all outputs return to reset values next cycle. Any pending reverse_req is cancelled.
- reverse_req is registered: it is high for exactly one cycle, the cycle after the causing event. Two causes never overlap because they require separate frame_stb/pellet cycles.
- Outputs mode, phase_idx, fright_flash and eat_count are registered. move_en is the only combinational output (frame_stb gated by state).
- Width rules: timer is CNT_W bits unsigned and never underflows (expiry is at 1, not 0). phase_idx never exceeds 2*NUM_PHASES-1.

Test Plan:
(Bench params: SCATTER_FRAMES=4, CHASE_FRAMES=6, FRIGHT_FRAMES=5, FLASH_FRAMES=2, NUM_PHASES=2.)
1. rst, then game_start, then 4 frame_stb -> mode=01 for 4 strobes, then mode=10, phase_idx=1, reverse_req high exactly 1 cycle, move_en equals frame_stb throughout.
2. Run through phases -> sequence S0(4) C1(6) S2(4) C3. phase_idx stays 3, mode=10 after 100 more strobes, no further reverse_req.
3. In SCATTER, after 2 strobes (timer=2), pellet_eaten -> mode=11 and reverse_req pulse. move_en is asserted on strobes 2 and 4 only. fright_flash rises once timer=2. After the 5th strobe, mode=01 with timer=2, and expiry occurs 2 strobes later.
4. In FRIGHT, 4 ghost_eaten pulses -> eat_count 1,2,3,3. pellet_eaten at timer=1 -> timer=5, eat_count=0, no reverse_req.
5. pellet_eaten on the same cycle as the expiring frame_stb (timer=1) -> FRIGHT entered, saved timer=1, phase_idx unchanged. On fright exit, expiry occurs on the first subsequent strobe.
6. pac_dead mid-FRIGHT, coincident with frame_stb -> next cycle mode=00, phase_idx=0, eat_count=0, fright_flash=0, move_en=0. game_start then restarts at S0 with timer=4.

Source files
------------

// File: rtl/ghost_mode_scheduler.sv
// Ghost mode scheduler: sequences timed SCATTER/CHASE phases, preempts them
// with FRIGHTENED mode on a power pellet, issues one-cycle direction-reversal
// requests and produces the per-frame ghost movement enable.
module ghost_mode_scheduler #(
   parameter int SCATTER_FRAMES = 420,
   parameter int CHASE_FRAMES   = 1200,
   parameter int FRIGHT_FRAMES  = 360,
   parameter int FLASH_FRAMES   = 120,
   parameter int NUM_PHASES     = 4,
   parameter int CNT_W          = 11
) (
   input  logic       vga_pix_clk,
   input  logic       rst,
   input  logic       frame_stb,
   input  logic       game_start,
   input  logic       pellet_eaten,
   input  logic       ghost_eaten,
   input  logic       pac_dead,
   output logic [1:0] mode,
   output logic [2:0] phase_idx,
   output logic       reverse_req,
   output logic       move_en,
   output logic       fright_flash,
   output logic [1:0] eat_count
);

   typedef enum logic [1:0] {
      MODE_IDLE    = 2'b00,
      MODE_SCATTER = 2'b01,
      MODE_CHASE   = 2'b10,
      MODE_FRIGHT  = 2'b11
   } mode_t;

   localparam logic [CNT_W-1:0] L_SCATTER    = CNT_W'(SCATTER_FRAMES);
   localparam logic [CNT_W-1:0] L_CHASE      = CNT_W'(CHASE_FRAMES);
   localparam logic [CNT_W-1:0] L_FRIGHT     = CNT_W'(FRIGHT_FRAMES);
   localparam logic [CNT_W-1:0] L_FLASH      = CNT_W'(FLASH_FRAMES);
   localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
   localparam logic [2:0]       L_LAST_PHASE = 3'(2 * NUM_PHASES - 1);
   // Flash level right after a fright (re)load
   localparam logic             L_LOAD_FLASH = (L_FRIGHT <= L_FLASH);

   mode_t            r_mode;
   mode_t            r_saved_mode;
   logic [2:0]       r_phase_idx;
   logic [2:0]       r_saved_phase;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] r_saved_timer;
   logic             r_toggle;
   logic             r_reverse_req;
   logic             r_fright_flash;
   logic [1:0]       r_eat_count;

   logic [2:0]       w_phase_next;
   logic [CNT_W-1:0] w_timer_dec;
   logic             w_expire;
   logic             w_final;

   assign w_phase_next = r_phase_idx + 3'd1;
   assign w_timer_dec  = r_timer - L_ONE;
   // Expiry happens at 1, so the timer never has to wrap through zero
   assign w_expire     = (r_timer == L_ONE);
   assign w_final      = (r_phase_idx == L_LAST_PHASE);

   assign mode         = r_mode;
   assign phase_idx    = r_phase_idx;
   assign reverse_req  = r_reverse_req;
   assign fright_flash = r_fright_flash;
   assign eat_count    = r_eat_count;

   // Gate the frame strobe by mode: full speed in scatter/chase, every other strobe in fright
   always_comb begin
      move_en = 1'b0;
      case (r_mode)
         MODE_IDLE:    move_en = 1'b0;
         MODE_SCATTER: move_en = frame_stb;
         MODE_CHASE:   move_en = frame_stb;
         MODE_FRIGHT:  move_en = frame_stb & r_toggle;
         default:      move_en = 1'b0;
      endcase
   end

   // Mode sequencer: event priority is rst/pac_dead, game_start, pellet, expiry, decrement
   always_ff @(posedge vga_pix_clk) begin
      if (rst || pac_dead) begin
         r_mode         <= MODE_IDLE;
         r_saved_mode   <= MODE_IDLE;
         r_phase_idx    <= 3'd0;
         r_saved_phase  <= 3'd0;
         r_timer        <= {CNT_W{1'b0}};
         r_saved_timer  <= {CNT_W{1'b0}};
         r_toggle       <= 1'b0;
         r_reverse_req  <= 1'b0;
         r_fright_flash <= 1'b0;
         r_eat_count    <= 2'd0;
      end else begin
         r_reverse_req <= 1'b0;
         if (game_start) begin
            r_mode         <= MODE_SCATTER;
            r_phase_idx    <= 3'd0;
            r_timer        <= L_SCATTER;
            r_toggle       <= 1'b0;
            r_fright_flash <= 1'b0;
         end else begin
            case (r_mode)
               MODE_SCATTER, MODE_CHASE: begin
                  if (pellet_eaten) begin
                     // Freeze the running phase exactly as it is, then enter fright
                     r_saved_mode   <= r_mode;
                     r_saved_phase  <= r_phase_idx;
                     r_saved_timer  <= r_timer;
                     r_mode         <= MODE_FRIGHT;
                     r_timer        <= L_FRIGHT;
                     r_eat_count    <= 2'd0;
                     r_toggle       <= 1'b0;
                     r_reverse_req  <= 1'b1;
                     r_fright_flash <= L_LOAD_FLASH;
                  end else if (frame_stb && !w_final) begin
                     if (w_expire) begin
                        r_phase_idx   <= w_phase_next;
                        r_mode        <= w_phase_next[0] ? MODE_CHASE : MODE_SCATTER;
                        r_timer       <= w_phase_next[0] ? L_CHASE : L_SCATTER;
                        r_reverse_req <= 1'b1;
                     end else begin
                        r_timer <= w_timer_dec;
                     end
                  end else begin
                     r_timer <= r_timer;
                  end
               end
               MODE_FRIGHT: begin
                  if (pellet_eaten) begin
                     // Extend fright without reversing; toggle phase is kept
                     r_timer        <= L_FRIGHT;
                     r_eat_count    <= 2'd0;
                     r_fright_flash <= L_LOAD_FLASH;
                  end else begin
                     if (ghost_eaten && (r_eat_count != 2'd3)) begin
                        r_eat_count <= r_eat_count + 2'd1;
                     end else begin
                        r_eat_count <= r_eat_count;
                     end
                     if (frame_stb) begin
                        r_toggle <= ~r_toggle;
                        if (w_expire) begin
                           // Resume the paused phase with its remaining count
                           r_mode         <= r_saved_mode;
                           r_phase_idx    <= r_saved_phase;
                           r_timer        <= r_saved_timer;
                           r_fright_flash <= 1'b0;
                        end else begin
                           r_timer        <= w_timer_dec;
                           r_fright_flash <= (w_timer_dec <= L_FLASH);
                        end
                     end else begin
                        r_timer <= r_timer;
                     end
                  end
               end
               default: begin
                  r_mode <= r_mode;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: per-cycle expected outputs are queued as
// stimulus is driven and compared against the captured DUT outputs.
module tb_ghost_mode_scheduler;

   localparam int SF  = 4;
   localparam int CF  = 6;
   localparam int FF  = 5;
   localparam int FLF = 2;
   localparam int NP  = 2;
   localparam int CW  = 11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_stb = 1'b0;
   logic       game_start = 1'b0;
   logic       pellet_eaten = 1'b0;
   logic       ghost_eaten = 1'b0;
   logic       pac_dead = 1'b0;
   logic [1:0] mode;
   logic [2:0] phase_idx;
   logic       reverse_req;
   logic       move_en;
   logic       fright_flash;
   logic [1:0] eat_count;

   int total = 0;
   int bad   = 0;

   // Packed as {mode, phase_idx, reverse_req, fright_flash, eat_count, move_en}
   logic [9:0] exp_q[$];
   logic [9:0] obs_q[$];
   string      name_q[$];

   always #5 clk = ~clk;

   ghost_mode_scheduler #(
      .SCATTER_FRAMES(SF), .CHASE_FRAMES(CF), .FRIGHT_FRAMES(FF),
      .FLASH_FRAMES(FLF), .NUM_PHASES(NP), .CNT_W(CW)
   ) dut (
      .vga_pix_clk (clk),
      .rst         (rst),
      .frame_stb   (frame_stb),
      .game_start  (game_start),
      .pellet_eaten(pellet_eaten),
      .ghost_eaten (ghost_eaten),
      .pac_dead    (pac_dead),
      .mode        (mode),
      .phase_idx   (phase_idx),
      .reverse_req (reverse_req),
      .move_en     (move_en),
      .fright_flash(fright_flash),
      .eat_count   (eat_count)
   );

   function automatic logic [9:0] ev(input logic [1:0] m, input logic [2:0] p, input logic r,
                                     input logic f, input logic [1:0] e, input logic mv);
      return {m, p, r, f, e, mv};
   endfunction

   // One clock cycle: apply inputs, sample move_en mid-cycle, registered outputs after the edge
   task automatic drive(input logic r, input logic fs, input logic gs, input logic pe,
                        input logic ge, input logic pd);
      logic mv;
      rst = r; frame_stb = fs; game_start = gs; pellet_eaten = pe; ghost_eaten = ge; pac_dead = pd;
      #2;
      mv = move_en;
      @(posedge clk);
      #1;
      obs_q.push_back({mode, phase_idx, reverse_req, fright_flash, eat_count, mv});
      rst = 1'b0; frame_stb = 1'b0; game_start = 1'b0;
      pellet_eaten = 1'b0; ghost_eaten = 1'b0; pac_dead = 1'b0;
   endtask

   task automatic want(input string n, input logic [9:0] e);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic test_reset;
      logic [9:0] e, o;
      string n;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("reset",       ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("idle_strobe", ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); want("idle_ignore", ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front(); total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL %s: no output captured, expected %b", n, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL %s: got %b expected %b (mode,phase,rev,flash,eat,move)", n, o, e); end
         end
      end
   endtask

   task automatic test_phases;
      logic [9:0] e, o;
      string n;
      int len;
      logic [1:0] m, nm;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); want("start", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      for (int ph = 0; ph < 2 * NP - 1; ph++) begin
         len = (ph % 2 == 0) ? SF : CF;
         m   = (ph % 2 == 0) ? 2'd1 : 2'd2;
         nm  = (ph % 2 == 0) ? 2'd2 : 2'd1;
         for (int k = 1; k <= len; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k < len) want($sformatf("ph%0d_stb%0d", ph, k), ev(m, 3'(ph), 1'b0, 1'b0, 2'd0, 1'b1));
            else         want($sformatf("ph%0d_expire", ph), ev(nm, 3'(ph + 1), 1'b1, 1'b0, 2'd0, 1'b1));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k < len) want($sformatf("ph%0d_gap%0d", ph, k), ev(m, 3'(ph), 1'b0, 1'b0, 2'd0, 1'b0));
            else         want($sformatf("ph%0d_revdrop", ph), ev(nm, 3'(ph + 1), 1'b0, 1'b0, 2'd0, 1'b0));
         end
      end
      for (int k = 0; k < 100; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         want($sformatf("final_chase_%0d", k), ev(2'd2, 3'd3, 1'b0, 1'b0, 2'd0, 1'b1));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front(); total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL %s: no output captured, expected %b", n, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL %s: got %b expected %b (mode,phase,rev,flash,eat,move)", n, o, e); end
         end
      end
   endtask

   task automatic test_fright_pause;
      logic [9:0] e, o;
      string n;
      logic mv, fl;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); want("fp_reset", ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); want("fp_start", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("fp_s1",    ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("fp_s2",    ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); want("fp_enter", ev(2'd3, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));
      for (int k = 1; k <= FF; k++) begin
         mv = (k % 2 == 0);
         fl = (k >= 3);
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (k < FF) begin
            want($sformatf("fp_f%0d", k), ev(2'd3, 3'd0, 1'b0, fl, 2'd0, mv));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            want($sformatf("fp_gap%0d", k), ev(2'd3, 3'd0, 1'b0, fl, 2'd0, 1'b0));
         end else begin
            want("fp_exit", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, mv));
         end
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("fp_resume1", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("fp_resume2", ev(2'd2, 3'd1, 1'b1, 1'b0, 2'd0, 1'b1));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front(); total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL %s: no output captured, expected %b", n, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL %s: got %b expected %b (mode,phase,rev,flash,eat,move)", n, o, e); end
         end
      end
   endtask

   task automatic test_eat_reload;
      logic [9:0] e, o;
      string n;
      logic [1:0] ec;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); want("er_reset", ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); want("er_start", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); want("er_enter", ev(2'd3, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));
      for (int k = 1; k <= 4; k++) begin
         ec = (k >= 3) ? 2'd3 : 2'(k);
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         want($sformatf("er_eat%0d", k), ev(2'd3, 3'd0, 1'b0, 1'b0, ec, 1'b0));
      end
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         want($sformatf("er_f%0d", k), ev(2'd3, 3'd0, 1'b0, (k >= 3), 2'd3, (k % 2 == 0)));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); want("er_reload", ev(2'd3, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); want("er_eat_again", ev(2'd3, 3'd0, 1'b0, 1'b0, 2'd1, 1'b0));
      for (int k = 1; k <= FF; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (k < FF) want($sformatf("er_g%0d", k), ev(2'd3, 3'd0, 1'b0, (k >= 3), 2'd1, (k % 2 == 0)));
         else        want("er_exit", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd1, 1'b0));
      end
      for (int k = 1; k <= SF; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (k < SF) want($sformatf("er_s%0d", k), ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1));
         else        want("er_s_expire", ev(2'd2, 3'd1, 1'b1, 1'b0, 2'd1, 1'b1));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front(); total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL %s: no output captured, expected %b", n, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL %s: got %b expected %b (mode,phase,rev,flash,eat,move)", n, o, e); end
         end
      end
   endtask

   task automatic test_coincide;
      logic [9:0] e, o;
      string n;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); want("co_reset", ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); want("co_start", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      for (int k = 1; k < SF; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         want($sformatf("co_s%0d", k), ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); want("co_enter", ev(2'd3, 3'd0, 1'b1, 1'b0, 2'd0, 1'b1));
      for (int k = 1; k <= FF; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (k < FF) want($sformatf("co_f%0d", k), ev(2'd3, 3'd0, 1'b0, (k >= 3), 2'd0, (k % 2 == 0)));
         else        want("co_exit", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("co_expire", ev(2'd2, 3'd1, 1'b1, 1'b0, 2'd0, 1'b1));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); want("co_revdrop", ev(2'd2, 3'd1, 1'b0, 1'b0, 2'd0, 1'b0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front(); total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL %s: no output captured, expected %b", n, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL %s: got %b expected %b (mode,phase,rev,flash,eat,move)", n, o, e); end
         end
      end
   endtask

   task automatic test_pac_dead;
      logic [9:0] e, o;
      string n;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); want("pd_reset", ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); want("pd_start", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); want("pd_enter", ev(2'd3, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); want("pd_eat",   ev(2'd3, 3'd0, 1'b0, 1'b0, 2'd1, 1'b0));
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         want($sformatf("pd_f%0d", k), ev(2'd3, 3'd0, 1'b0, (k >= 3), 2'd1, (k % 2 == 0)));
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); want("pd_dead",   ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); want("pd_idle",   ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); want("pd_restart", ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      for (int k = 1; k <= SF; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (k < SF) want($sformatf("pd_s%0d", k), ev(2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1));
         else        want("pd_s_expire", ev(2'd2, 3'd1, 1'b1, 1'b0, 2'd0, 1'b1));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); want("pd_over_pellet", ev(2'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front(); total++;
         if (obs_q.size() == 0) begin
            bad++; $display("FAIL %s: no output captured, expected %b", n, e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin bad++; $display("FAIL %s: got %b expected %b (mode,phase,rev,flash,eat,move)", n, o, e); end
         end
      end
   endtask

   // Test sequence
   initial begin
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset;
      test_phases;
      test_fright_pause;
      test_eat_reload;
      test_coincide;
      test_pac_dead;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
